// File: rtl/ccd_adc_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_adc_capture_pkg
//  Description : FSM encoding, pixel-tag layout and ILX511B frame constants
//                shared by the ADC capture path and the ILX511B timing logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package ccd_adc_capture_pkg;

  localparam int c_PIX_IDX_W = 12;

  // ILX511B frame geometry: 32 leading dummies, 2048 effective, 6 trailing
  localparam int c_ILX_PIX_TOTAL = 2086;
  localparam int c_ILX_SKIP_HEAD = 32;
  localparam int c_ILX_PIX_OUT   = 2048;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CONV  = 2'd1;
  localparam logic [1:0] c_ST_SHIFT = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  typedef struct packed {
    logic                   sof;
    logic                   eof;
    logic [c_PIX_IDX_W-1:0] idx;
  } pix_tag_t;

  localparam int c_TAG_W = $bits(pix_tag_t);

  function automatic logic pix_in_window(
    input logic [c_PIX_IDX_W-1:0] n,
    input logic [c_PIX_IDX_W-1:0] first,
    input logic [c_PIX_IDX_W-1:0] last_excl
  );
    return (n >= first) && (n < last_excl);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccd_pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_pix_fifo
//  Description : Synchronous first-word-fall-through FIFO for tagged pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_pix_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_rd;
  logic              w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_FULL);
  assign w_rd    = i_rd_en && !o_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO succeeds
  assign w_wr    = i_wr_en && (!o_full || w_rd);

  // Head is gated so the output reads zero while nothing is stored
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ccd_adc_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_adc_capture
//  Description : Serial-ADC conversion sequencer with pixel tagging, head-dummy
//                removal and a FWFT valid/ready output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_adc_capture
  import ccd_adc_capture_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CNV_CYCLES = 40,
  parameter int SCK_DIV    = 2,
  parameter int PIX_TOTAL  = c_ILX_PIX_TOTAL,
  parameter int SKIP_HEAD  = c_ILX_SKIP_HEAD,
  parameter int PIX_OUT    = c_ILX_PIX_OUT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   flag_adc_start,
  input  logic                   flag_adc_restart,
  output logic                   adc_cnv,
  output logic                   adc_sck,
  input  logic                   adc_sdo,
  output logic [DATA_W-1:0]      pix_data,
  output logic [c_PIX_IDX_W-1:0] pix_idx,
  output logic                   pix_sof,
  output logic                   pix_eof,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   frame_done,
  output logic                   err_overlap,
  output logic                   err_overrun
);

  localparam int CNT_W  = $clog2(CNV_CYCLES + 1);
  localparam int DIV_W  = $clog2(SCK_DIV + 1);
  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int FIFO_W = DATA_W + c_TAG_W;

  localparam logic [CNT_W-1:0]       c_CNV_LAST  = CNT_W'(CNV_CYCLES - 1);
  localparam logic [DIV_W-1:0]       c_DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0]       c_BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [c_PIX_IDX_W-1:0] c_SKIP      = c_PIX_IDX_W'(SKIP_HEAD);
  localparam logic [c_PIX_IDX_W-1:0] c_WIN_END   = c_PIX_IDX_W'(SKIP_HEAD + PIX_OUT);
  localparam logic [c_PIX_IDX_W-1:0] c_IDX_LAST  = c_PIX_IDX_W'(PIX_OUT - 1);
  localparam logic [c_PIX_IDX_W-1:0] c_TOTAL     = c_PIX_IDX_W'(PIX_TOTAL);
  localparam logic [c_PIX_IDX_W-1:0] c_TOTAL_M1  = c_PIX_IDX_W'(PIX_TOTAL - 1);

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnv_cnt;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit;
  logic                   r_cnv;
  logic                   r_sck;
  logic [DATA_W-1:0]      r_shift;
  logic [c_PIX_IDX_W-1:0] r_pix_n;
  logic                   r_frame_done;
  logic                   r_err_overlap;
  logic                   r_err_overrun;
  logic                   r_push;
  logic [FIFO_W-1:0]      r_push_word;

  pix_tag_t               w_tag;
  logic                   w_in_window;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_overrun;
  logic [FIFO_W-1:0]      w_head;

  assign w_in_window = pix_in_window(r_pix_n, c_SKIP, c_WIN_END);

  always_comb begin
    w_tag     = '0;
    w_tag.idx = r_pix_n - c_SKIP;
    w_tag.sof = (w_tag.idx == '0);
    w_tag.eof = (w_tag.idx == c_IDX_LAST);
  end

  assign w_pop     = pix_valid && pix_ready;
  assign w_overrun = r_push && w_fifo_full && !w_pop;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || flag_adc_restart) begin
      r_state       <= c_ST_IDLE;
      r_cnv_cnt     <= '0;
      r_div         <= '0;
      r_bit         <= '0;
      r_cnv         <= 1'b0;
      r_sck         <= 1'b0;
      r_shift       <= '0;
      r_pix_n       <= '0;
      r_frame_done  <= 1'b0;
      r_err_overlap <= 1'b0;
      r_err_overrun <= 1'b0;
      r_push        <= 1'b0;
      r_push_word   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_push       <= 1'b0;
      if (flag_adc_start && (r_state != c_ST_IDLE)) begin
        r_err_overlap <= 1'b1;
      end
      if (w_overrun) begin
        r_err_overrun <= 1'b1;
      end
      case (r_state)
        c_ST_IDLE: begin
          if (flag_adc_start) begin
            r_state   <= c_ST_CONV;
            r_cnv     <= 1'b1;
            r_cnv_cnt <= '0;
          end
        end
        c_ST_CONV: begin
          if (r_cnv_cnt == c_CNV_LAST) begin
            r_state <= c_ST_SHIFT;
            r_cnv   <= 1'b0;
            r_div   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnv_cnt <= r_cnv_cnt + 1'b1;
          end
        end
        c_ST_SHIFT: begin
          if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            if (!r_sck) begin
              // Data is captured on the same edge that raises SCK
              r_sck   <= 1'b1;
              r_shift <= {r_shift[DATA_W-2:0], adc_sdo};
            end else begin
              r_sck <= 1'b0;
              if (r_bit == c_BIT_LAST) begin
                r_state <= c_ST_DONE;
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
          if (r_pix_n != c_TOTAL) begin
            r_pix_n <= r_pix_n + 1'b1;
            if (r_pix_n == c_TOTAL_M1) begin
              r_frame_done <= 1'b1;
            end
          end
          if (w_in_window) begin
            r_push      <= 1'b1;
            r_push_word <= {w_tag, r_shift};
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  ccd_pix_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .i_flush   (flag_adc_restart),
    .i_wr_en   (r_push),
    .i_wr_data (r_push_word),
    .i_rd_en   (pix_ready),
    .o_rd_data (w_head),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign adc_cnv     = r_cnv;
  assign adc_sck     = r_sck;
  assign pix_valid   = !w_fifo_empty;
  assign pix_data    = w_head[DATA_W-1:0];
  assign pix_idx     = w_head[DATA_W +: c_PIX_IDX_W];
  assign pix_eof     = w_head[DATA_W + c_PIX_IDX_W];
  assign pix_sof     = w_head[DATA_W + c_PIX_IDX_W + 1];
  assign frame_done  = r_frame_done;
  assign err_overlap = r_err_overlap;
  assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire
